// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: FSM encoding, word size and EX/MEM control-bit indices.
package mem_stage_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  localparam int unsigned WORD_BYTES = 4;

  // Bit positions of the control word carried in the EX/MEM and MEM/WB buffers
  localparam int unsigned CTRL_REG_WRITE = 0;
  localparam int unsigned CTRL_MEM_TO_REG = 1;
  localparam int unsigned CTRL_MEM_WRITE = 2;
  localparam int unsigned CTRL_MEM_READ = 3;
  localparam int unsigned CTRL_BRANCH = 4;
  localparam int unsigned CTRL_W = 5;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs and MEM/WB outputs of the MEM stage; slave is the stage, master the surroundings.
// Optional MEM_ALIGN_CHECK_EN adds the registered outAlignErr flag.
interface mem_stage_if;

  logic        inReg2;
  logic        inMemReg2;
  logic        inMemW2;
  logic        inMemR2;
  logic        inBranch2;
  logic        inZFlag;
  logic [31:0] inBranchRes;
  logic [31:0] inALURes1;
  logic [31:0] inDR2V;
  logic [4:0]  inRegMux1;
  logic        outPCSrc;
  logic [31:0] outBranchTarget;
  logic        outStall;
  logic        outReg3;
  logic        outMemReg3;
  logic [31:0] outReadData;
  logic [31:0] outALURes2;
  logic [4:0]  outRegMux2;
`ifdef MEM_ALIGN_CHECK_EN
  logic        outAlignErr;
`endif

  modport slave (
    input  inReg2, inMemReg2, inMemW2, inMemR2, inBranch2, inZFlag,
    input  inBranchRes, inALURes1, inDR2V, inRegMux1,
`ifdef MEM_ALIGN_CHECK_EN
    output outAlignErr,
`endif
    output outPCSrc, outBranchTarget, outStall, outReg3, outMemReg3,
    output outReadData, outALURes2, outRegMux2
  );

  modport master (
    output inReg2, inMemReg2, inMemW2, inMemR2, inBranch2, inZFlag,
    output inBranchRes, inALURes1, inDR2V, inRegMux1,
`ifdef MEM_ALIGN_CHECK_EN
    input  outAlignErr,
`endif
    input  outPCSrc, outBranchTarget, outStall, outReg3, outMemReg3,
    input  outReadData, outALURes2, outRegMux2
  );

endinterface

// File: rtl/mem_stage_data_memory.sv
// Word-wide data memory: synchronous write on we, asynchronous read. Contents are never reset.
module data_memory #(
  parameter int unsigned DEPTH_WORDS = 64,
  localparam int unsigned AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage.sv
// MIPS MEM stage: branch resolution, wait-stated data memory access with stall, MEM/WB register.
// Optional MEM_ALIGN_CHECK_EN flags and suppresses misaligned accesses without stalling.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_STATES = 1
) (
  input logic       clk,
  input logic       rst,
  mem_stage_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned LSB = $clog2(WORD_BYTES);
  localparam logic [3:0] CntInit = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e            state_q;
  logic [3:0]        cnt_q;
  logic [CTRL_W-1:0] ctrl;
  logic              req;
  logic              misalign;
  logic              stall;
  logic              we;
  logic [31:0]       rd_word;

  assign ctrl = {bus.inBranch2, bus.inMemR2, bus.inMemW2, bus.inMemReg2, bus.inReg2};
  assign req  = ctrl[CTRL_MEM_READ] | ctrl[CTRL_MEM_WRITE];

`ifdef MEM_ALIGN_CHECK_EN
  assign misalign = req & (|bus.inALURes1[LSB-1:0]);
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    stall = 1'b0;
    case (state_q)
      StIdle: stall = req && (WAIT_STATES > 0) && !misalign;
      StBusy: stall = (cnt_q != 4'd0);
      default: stall = 1'b0;
    endcase
  end

  assign we                  = ctrl[CTRL_MEM_WRITE] & ~stall & ~misalign;
  assign bus.outStall        = stall;
  assign bus.outPCSrc        = ctrl[CTRL_BRANCH] & bus.inZFlag;
  assign bus.outBranchTarget = bus.inBranchRes;

  data_memory #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_dmem (
    .clk  (clk),
    .we   (we),
    .addr (bus.inALURes1[AW+LSB-1:LSB]),
    .wdata(bus.inDR2V),
    .rdata(rd_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      cnt_q           <= 4'd0;
      bus.outReg3     <= 1'b0;
      bus.outMemReg3  <= 1'b0;
      bus.outReadData <= 32'd0;
      bus.outALURes2  <= 32'd0;
      bus.outRegMux2  <= 5'd0;
`ifdef MEM_ALIGN_CHECK_EN
      bus.outAlignErr <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (stall) begin
            state_q <= StBusy;
            cnt_q   <= CntInit;
          end
        end
        StBusy: begin
          if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q <= StIdle;
          end
        end
      endcase

      if (stall) begin
        // Bubble into WB; data fields hold their last value
        bus.outReg3    <= 1'b0;
        bus.outMemReg3 <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
        bus.outAlignErr <= 1'b0;
`endif
      end else begin
        bus.outReg3     <= ctrl[CTRL_REG_WRITE] & ~misalign;
        bus.outMemReg3  <= ctrl[CTRL_MEM_TO_REG];
        bus.outReadData <= (ctrl[CTRL_MEM_READ] && !misalign) ? rd_word : 32'd0;
        bus.outALURes2  <= bus.inALURes1;
        bus.outRegMux2  <= bus.inRegMux1;
`ifdef MEM_ALIGN_CHECK_EN
        bus.outAlignErr <= misalign;
`endif
      end
    end
  end

endmodule
